// File: rtl/grid_result_collector_pkg.sv
// Shared solver definitions for the grid result collector: FSM state encoding,
// iteration counter width and small counter helpers.
package grid_result_collector_pkg;

  localparam int ITER_W = 16;
  localparam logic [ITER_W-1:0] ITER_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SNAP,
    S_STREAM,
    S_DONE
  } solverState_t;

  // A zero limit means "run as long as the iteration counter can count".
  function automatic logic [ITER_W-1:0] effectiveLimit(input logic [ITER_W-1:0] limit);
    return (limit == '0) ? ITER_MAX : limit;
  endfunction

  function automatic logic [ITER_W-1:0] satInc(input logic [ITER_W-1:0] value);
    return (value == ITER_MAX) ? value : value + ITER_W'(1);
  endfunction

endpackage

// File: rtl/grid_snapshot_buf.sv
// Snapshot of all cell values taken at the end of a solve, read back one cell
// at a time through a non-wrapping stream index.
module grid_snapshot_buf #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             latch,
  input  logic             advance,
  input  logic [8*N-1:0]   cellVals,
  output logic [IDX_W-1:0] idx,
  output logic [7:0]       data,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [7:0] snapMem [N];

  // Contents are only meaningful after a latch, so they carry no reset.
  always_ff @(posedge clk) begin
    if (latch) begin
      for (int k = 0; k < N; k++) begin
        snapMem[k] <= cellVals[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (latch) begin
      idx <= '0;
    end else if (advance && idx != LAST_IDX) begin
      idx <= idx + IDX_W'(1);
    end
  end

  assign data = snapMem[idx];
  assign last = (idx == LAST_IDX);

endmodule

// File: rtl/grid_result_collector.sv
// Runs the grid until it converges or hits the iteration limit, then snapshots
// every cell value and streams them out in row-major order.
module grid_result_collector
  import grid_result_collector_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int STABLE_ITERS = 3,
  localparam int N           = ROWS * COLS,
  localparam int IDX_W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ITER_W-1:0] iterLimit,
  input  logic              iterTick,
  input  logic [N-1:0]      cellConv,
  input  logic [8*N-1:0]    cellVals,
  output logic              run,
  output logic              outValid,
  input  logic              outReady,
  output logic [7:0]        outData,
  output logic [IDX_W-1:0]  outIdx,
  output logic              outLast,
  output logic              done,
  output logic              timeout,
  output logic [ITER_W-1:0] iterCount
);

  localparam logic [ITER_W-1:0] STABLE_TARGET = ITER_W'(STABLE_ITERS);

  solverState_t      state;
  logic [ITER_W-1:0] stableCnt;
  logic [ITER_W-1:0] nextCount;
  logic [ITER_W-1:0] nextStable;
  logic              resetReleased;
  logic [IDX_W-1:0]  bufIdx;
  logic [7:0]        bufData;
  logic              bufLast;

  always_comb begin
    nextCount  = satInc(iterCount);
    nextStable = (&cellConv) ? satInc(stableCnt) : '0;
  end

  // resetReleased keeps a START on the first edge after reset from launching a solve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      run           <= 1'b0;
      outValid      <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      iterCount     <= '0;
      stableCnt     <= '0;
      resetReleased <= 1'b0;
    end else begin
      resetReleased <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start && resetReleased) begin
            state     <= S_RUN;
            run       <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            iterCount <= '0;
            stableCnt <= '0;
          end
        end
        S_RUN: begin
          if (iterTick) begin
            iterCount <= nextCount;
            stableCnt <= nextStable;
            // Convergence is tested first so it wins a tie with the limit.
            if (nextStable == STABLE_TARGET) begin
              state   <= S_SNAP;
              run     <= 1'b0;
              timeout <= 1'b0;
            end else if (nextCount == effectiveLimit(iterLimit)) begin
              state   <= S_SNAP;
              run     <= 1'b0;
              timeout <= 1'b1;
            end
          end
        end
        S_SNAP: begin
          state    <= S_STREAM;
          outValid <= 1'b1;
        end
        S_STREAM: begin
          if (outReady && bufLast) begin
            state    <= S_DONE;
            outValid <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          run      <= 1'b0;
          outValid <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  grid_snapshot_buf #(
    .N     (N),
    .IDX_W (IDX_W)
  ) snapshotBuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .latch    (state == S_SNAP),
    .advance  (outValid && outReady),
    .cellVals (cellVals),
    .idx      (bufIdx),
    .data     (bufData),
    .last     (bufLast)
  );

  assign outData = outValid ? bufData : '0;
  assign outIdx  = outValid ? bufIdx : '0;
  assign outLast = outValid && bufLast;

endmodule

// File: tb/tb_grid_result_collector.sv
// Randomized bench for grid_result_collector with a tick-level reference model
// of the solve (count, stability, limit) and of the streamed snapshot.
module tb_grid_result_collector;

  localparam int N = 16;
  localparam int STABLE = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [15:0]    iterLimit = '0;
  logic           iterTick = 1'b0;
  logic [N-1:0]   cellConv = '0;
  logic [8*N-1:0] cellVals = '0;
  logic           outReady = 1'b0;
  logic           run, outValid, outLast, done, timeout;
  logic [7:0]     outData;
  logic [3:0]     outIdx;
  logic [15:0]    iterCount;

  int errors = 0;
  int checks = 0;
  logic [N-1:0] convSeq[$];
  logic [7:0]   expVals[N];

  grid_result_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .iterLimit (iterLimit),
    .iterTick  (iterTick),
    .cellConv  (cellConv),
    .cellVals  (cellVals),
    .run       (run),
    .outValid  (outValid),
    .outReady  (outReady),
    .outData   (outData),
    .outIdx    (outIdx),
    .outLast   (outLast),
    .done      (done),
    .timeout   (timeout),
    .iterCount (iterCount)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] notAllConv();
    logic [N-1:0] p = N'($urandom);
    p[$urandom_range(0, N-1)] = 1'b0;
    return p;
  endfunction

  task automatic loadVals(input bit randomVals);
    for (int k = 0; k < N; k++) begin
      expVals[k] = randomVals ? 8'($urandom) : 8'(16 + k);
      cellVals[8*k +: 8] = expVals[k];
    end
  endtask

  task automatic doStart(input string name);
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    checks++;
    if ({run, done, timeout, iterCount} !== {1'b1, 1'b0, 1'b0, 16'd0})
      begin
        errors++;
        $display("[TB] FAIL %s start: run=%b done=%b timeout=%b iterCount=%0d want 1 0 0 0",
                 name, run, done, timeout, iterCount);
      end
  endtask

  // Model: count every tick, stability counts consecutive all-converged ticks,
  // reaching STABLE ends the solve cleanly, else reaching the limit times out.
  task automatic runSolve(input logic [15:0] limit, input string name);
    int cnt = 0;
    int stab = 0;
    int effLim;
    bit ended = 1'b0;
    bit expTimeout = 1'b0;
    iterLimit = limit;
    effLim = (limit == 16'd0) ? 65535 : int'(limit);
    doStart(name);
    foreach (convSeq[i]) begin
      if (!ended) begin
        repeat ($urandom_range(0, 2)) begin
          cellConv = N'($urandom);
          start = 1'($urandom);
          nextCycle();
        end
        start = 1'b0;
        iterTick = 1'b1;
        cellConv = convSeq[i];
        nextCycle();
        iterTick = 1'b0;
        cellConv = N'($urandom);
        cnt++;
        stab = (&convSeq[i]) ? stab + 1 : 0;
        if (stab == STABLE) begin
          ended = 1'b1;
          expTimeout = 1'b0;
        end else if (cnt == effLim) begin
          ended = 1'b1;
          expTimeout = 1'b1;
        end
        checks++;
        if (run !== !ended || iterCount !== 16'(cnt)) begin
          errors++;
          $display("[TB] FAIL %s tick %0d: run=%b iterCount=%0d want run=%b iterCount=%0d",
                   name, cnt, run, iterCount, !ended, cnt);
        end
      end
    end
    checks++;
    if (timeout !== expTimeout) begin
      errors++;
      $display("[TB] FAIL %s timeout: got %b want %b", name, timeout, expTimeout);
    end
    checks++;
    if (outValid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s snap state: outValid=%b done=%b want 0 0", name, outValid, done);
    end
  endtask

  task automatic streamBeats(input int stopAfter, input bit scramble, input string name);
    int beats = 0;
    outReady = 1'b0;
    nextCycle();
    checks++;
    if (outValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s stream entry: outValid=%b want 1", name, outValid);
    end
    while (beats < stopAfter) begin
      checks++;
      if (outValid !== 1'b1 || outIdx !== 4'(beats) || outData !== expVals[beats] ||
          outLast !== (beats == N-1)) begin
        errors++;
        $display("[TB] FAIL %s beat %0d: valid=%b idx=%0d data=%h last=%b want 1 %0d %h %b",
                 name, beats, outValid, outIdx, outData, outLast, beats, expVals[beats],
                 (beats == N-1));
      end
      outReady = ~outReady;
      start = 1'($urandom);
      nextCycle();
      if (outReady) begin
        beats++;
        if (scramble) cellVals = '1;
      end
    end
    start = 1'b0;
    outReady = 1'b0;
    if (stopAfter == N) begin
      checks++;
      if (outValid !== 1'b0 || done !== 1'b1 || outLast !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s done: outValid=%b done=%b outLast=%b want 0 1 0",
                 name, outValid, done, outLast);
      end
    end
  endtask

  task automatic checkAllZero(input string name);
    checks++;
    if ({run, outValid, outLast, done, timeout, iterCount, outData, outIdx} !== '0) begin
      errors++;
      $display("[TB] FAIL %s: run=%b valid=%b last=%b done=%b timeout=%b cnt=%0d data=%h idx=%0d want all 0",
               name, run, outValid, outLast, done, timeout, iterCount, outData, outIdx);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2 checkAllZero("reset");
    #9 rst_n = 1'b1;
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    checks++;
    if (run !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start on release edge: run=%b want 0", run);
    end
    nextCycle();
  endtask

  task automatic test_converge();
    convSeq = {};
    repeat (3) convSeq.push_back('1);
    loadVals(1'b0);
    runSolve(16'd0, "converge");
    streamBeats(N, 1'b0, "converge stream");
  endtask

  task automatic test_timeout();
    convSeq = {};
    repeat (6) convSeq.push_back(notAllConv());
    loadVals(1'b1);
    runSolve(16'd5, "timeout");
    streamBeats(N, 1'b0, "timeout stream");
  endtask

  task automatic test_limit_tie();
    convSeq = {};
    convSeq.push_back(notAllConv());
    convSeq.push_back(notAllConv());
    repeat (3) convSeq.push_back('1);
    loadVals(1'b1);
    runSolve(16'd5, "limit tie");
    streamBeats(N, 1'b0, "limit tie stream");
  endtask

  task automatic test_stability_broken();
    convSeq = {};
    convSeq.push_back('1);
    convSeq.push_back('1);
    convSeq.push_back(notAllConv());
    repeat (3) convSeq.push_back('1);
    loadVals(1'b1);
    runSolve(16'd0, "stability broken");
    streamBeats(N, 1'b0, "stability stream");
  endtask

  task automatic test_scramble();
    convSeq = {};
    repeat (3) convSeq.push_back('1);
    loadVals(1'b0);
    runSolve(16'd0, "scramble");
    streamBeats(N, 1'b1, "scramble stream");
  endtask

  task automatic test_reset_midstream();
    convSeq = {};
    repeat (3) convSeq.push_back('1);
    loadVals(1'b1);
    runSolve(16'd0, "midstream");
    streamBeats(8, 1'b0, "midstream stream");
    rst_n = 1'b0;
    #1 checkAllZero("midstream reset");
    #2 rst_n = 1'b1;
    nextCycle();
    nextCycle();
    loadVals(1'b1);
    runSolve(16'd0, "post reset");
    streamBeats(N, 1'b0, "post reset stream");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      convSeq = {};
      repeat (12) convSeq.push_back($urandom_range(0, 1) ? '1 : notAllConv());
      loadVals(1'b1);
      runSolve(16'($urandom_range(1, 10)), "random");
      streamBeats(N, 1'b0, "random stream");
    end
  endtask

  initial begin
    test_reset();
    test_converge();
    test_timeout();
    test_limit_tie();
    test_stability_broken();
    test_scramble();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
